// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - whack-a-box round controller: LFSR targets, hit window, round timer, score, sound pulses
// Optional DIFFICULTY_RAMP_EN: streak-driven shrinking hit window.
`timescale 1ns/1ps
module game_round_ctrl #(
    parameter int NUM_BOXES     = 7,
    parameter int ADDR_W        = 3,
    parameter int CLK_HZ        = 50000000,
    parameter int ROUND_SECONDS = 60,
    parameter int TARGET_CYCLES = 75000000,
    parameter int SCORE_W       = 11,
    parameter int SOUND_CYCLES  = 25000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start_game,
    input  logic [ADDR_W-1:0]  box_address,
    output logic [ADDR_W-1:0]  target_box,
    output logic [SCORE_W-1:0] score,
    output logic [6:0]         seconds_left,
    output logic [1:0]         state_o,
    output logic               lobby_sound,
    output logic               hit_sound,
    output logic               miss_sound,
    output logic               game_over
);

    typedef enum logic [1:0] {
        LOBBY    = 2'd0,
        SPAWN    = 2'd1,
        WAIT_HIT = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam int PRESC_W = $clog2(CLK_HZ + 1);
    localparam int WIN_W   = $clog2(TARGET_CYCLES + 1);
    localparam int SND_W   = $clog2(SOUND_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [WIN_W-1:0]   WIN_FULL  = WIN_W'(TARGET_CYCLES);
    localparam logic [6:0]         SECS_INIT = 7'(ROUND_SECONDS);
    localparam logic [SND_W-1:0]   SND_LOAD  = SND_W'(SOUND_CYCLES);

    state_t              state, next_state;
    logic [7:0]          lfsr;
    logic                lfsr_fb;
    logic [ADDR_W-1:0]   s1, s2, s3;
    logic [PRESC_W-1:0]  presc;
    logic [WIN_W-1:0]    win_cnt;
    logic [WIN_W-1:0]    win_len;
    logic [SND_W-1:0]    hit_cnt, miss_cnt;
    logic [ADDR_W-1:0]   spawn_target;
    int                  cand;
    logic                hit_ev, in_play, start_req, sec_wrap, expire;
    logic                correct_hit, wrong_hit, timeout;

    always_comb begin
        lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        hit_ev      = (s2 != '0) && (s2 != s3);
        in_play     = (state == SPAWN) || (state == WAIT_HIT);
        start_req   = ((state == LOBBY) || (state == OVER)) && start_game;
        sec_wrap    = in_play && (presc == PRESC_W'(CLK_HZ - 1));
        expire      = sec_wrap && (seconds_left == 7'd1);
        correct_hit = (state == WAIT_HIT) && hit_ev && (s2 == target_box);
        wrong_hit   = (state == WAIT_HIT) && hit_ev && (s2 != target_box);
        // any hit event on the timeout edge wins over the timeout
        timeout     = (state == WAIT_HIT) && !hit_ev && (win_cnt >= win_len - WIN_W'(1));

        cand = int'(lfsr) % NUM_BOXES + 1;
        if (cand == int'(target_box)) begin
            cand = (cand >= NUM_BOXES) ? 1 : cand + 1;
        end
        spawn_target = ADDR_W'(cand);

        next_state = state;
        case (state)
            LOBBY:    if (start_game) next_state = SPAWN;
            SPAWN:    next_state = WAIT_HIT;
            WAIT_HIT: if (correct_hit || timeout) next_state = SPAWN;
            OVER:     if (start_game) next_state = SPAWN;
            default:  next_state = LOBBY;
        endcase
        if (expire) begin
            next_state = OVER;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= LOBBY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lfsr         <= 8'hA5;
            s1           <= '0;
            s2           <= '0;
            s3           <= '0;
            presc        <= '0;
            win_cnt      <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            target_box   <= '0;
            score        <= '0;
            seconds_left <= SECS_INIT;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            s1   <= box_address;
            s2   <= s1;
            s3   <= s2;

            if (hit_cnt != '0)  hit_cnt  <= hit_cnt - SND_W'(1);
            if (miss_cnt != '0) miss_cnt <= miss_cnt - SND_W'(1);

            if (start_req) begin
                score        <= '0;
                seconds_left <= SECS_INIT;
                presc        <= '0;
            end

            if (sec_wrap) begin
                presc        <= '0;
                seconds_left <= seconds_left - 7'd1;
            end else if (in_play) begin
                presc <= presc + PRESC_W'(1);
            end

            if (state == SPAWN) begin
                target_box <= spawn_target;
                win_cnt    <= '0;
            end else if (state == WAIT_HIT && win_cnt != '1) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end

            if (correct_hit) begin
                if (score != SCORE_MAX) score <= score + SCORE_W'(1);
                hit_cnt <= SND_LOAD;
            end
            if (wrong_hit) begin
                if (score != '0) score <= score - SCORE_W'(1);
                miss_cnt <= SND_LOAD;
            end
            if (timeout) begin
                miss_cnt <= SND_LOAD;
            end
            if (expire) begin
                target_box <= '0;
            end
        end
    end

`ifdef DIFFICULTY_RAMP_EN
    localparam logic [WIN_W-1:0] WIN_MIN = WIN_W'(TARGET_CYCLES / 8);
    logic [1:0] streak;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            win_len <= WIN_FULL;
            streak  <= '0;
        end else if (start_req || wrong_hit || timeout) begin
            win_len <= WIN_FULL;
            streak  <= '0;
        end else if (correct_hit) begin
            if (streak == 2'd3) begin
                streak  <= '0;
                win_len <= ((win_len >> 1) < WIN_MIN) ? WIN_MIN : (win_len >> 1);
            end else begin
                streak <= streak + 2'd1;
            end
        end
    end
`else
    assign win_len = WIN_FULL;
`endif

    assign state_o     = state;
    assign lobby_sound = (state == LOBBY);
    assign game_over   = (state == OVER);
    assign hit_sound   = (hit_cnt != '0);
    assign miss_sound  = (miss_cnt != '0);

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - self-checking bench for game_round_ctrl against a rule-level game model
`timescale 1ns/1ps
module tb_game_round_ctrl;
    localparam int NB = 7;
    localparam int CLK_HZ = 100;
    localparam int RS = 3;
    localparam int TC = 50;
    localparam int SC = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start_game;
    logic [2:0]  box_address;
    logic [2:0]  target_box;
    logic [10:0] score;
    logic [6:0]  seconds_left;
    logic [1:0]  state_o;
    logic        lobby_sound, hit_sound, miss_sound, game_over;

    game_round_ctrl #(
        .NUM_BOXES(NB), .ADDR_W(3), .CLK_HZ(CLK_HZ), .ROUND_SECONDS(RS),
        .TARGET_CYCLES(TC), .SCORE_W(11), .SOUND_CYCLES(SC)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game),
        .box_address(box_address), .target_box(target_box), .score(score),
        .seconds_left(seconds_left), .state_o(state_o), .lobby_sound(lobby_sound),
        .hit_sound(hit_sound), .miss_sound(miss_sound), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors = 0;
    int miscompares = 0;

    // game model: round progress as elapsed play cycles, pulses as trigger timestamps
    int m_state, m_target, m_score, m_elapsed, m_since, m_lfsr;
    int m_hit_t, m_miss_t, m_now, m_window, m_streak;
    int h[3];
    int hi_count = 0;
    int mi_count = 0;

    typedef struct {
        bit start;
        int sel;
        int cycles;
        int exp_state;
        int exp_score;
    } vec_t;
    vec_t tbl[10];
    int tgt_snap[10];
    int hi_snap[10];
    int mi_snap[10];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(input string name, input bit ok, input int act);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, condition not met at %0t", name, act, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_target = 0; m_score = 0; m_elapsed = 0; m_since = 0;
        m_lfsr = 8'hA5; m_hit_t = -1000; m_miss_t = -1000; m_now = 0;
        m_window = TC; m_streak = 0;
        h[0] = 0; h[1] = 0; h[2] = 0;
    endtask

    function automatic int pick();
        int c;
        c = m_lfsr % NB + 1;
        if (c == m_target) c = (c == NB) ? 1 : c + 1;
        return c;
    endfunction

    task automatic on_miss_streak();
        m_streak = 0;
        m_window = TC;
    endtask

    task automatic model_step(input bit st_in, input int addr_in);
        bit ev, active, expire;
        int fb;
        ev = (h[1] != 0) && (h[1] != h[2]);
        active = (m_state == 1) || (m_state == 2);
        expire = active && (m_elapsed == RS * CLK_HZ - 1);
        if ((m_state == 0 || m_state == 3) && st_in) begin
            m_state = 1; m_score = 0; m_elapsed = 0;
            on_miss_streak();
        end else if (m_state == 1) begin
            m_target = pick(); m_since = 0; m_state = 2;
        end else if (m_state == 2) begin
            if (ev && h[1] == m_target) begin
                if (m_score < 2047) m_score++;
                m_hit_t = m_now; m_state = 1;
`ifdef DIFFICULTY_RAMP_EN
                m_streak++;
                if (m_streak == 4) begin
                    m_streak = 0;
                    m_window = (m_window / 2 < TC / 8) ? TC / 8 : m_window / 2;
                end
`endif
            end else if (ev) begin
                if (m_score > 0) m_score--;
                m_miss_t = m_now; m_since++;
                on_miss_streak();
            end else if (m_since >= m_window - 1) begin
                m_miss_t = m_now; m_state = 1;
                on_miss_streak();
            end else begin
                m_since++;
            end
        end
        if (active) m_elapsed++;
        if (expire) begin
            m_state = 3; m_target = 0;
        end
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
        h[2] = h[1]; h[1] = h[0]; h[0] = addr_in;
        m_now++;
    endtask

    task automatic check_all();
        chk("state", int'(state_o), m_state);
        chk("target", int'(target_box), m_target);
        chk("score", int'(score), m_score);
        chk("seconds", int'(seconds_left), RS - m_elapsed / CLK_HZ);
        chk("lobby_sound", int'(lobby_sound), int'(m_state == 0));
        chk("game_over", int'(game_over), int'(m_state == 3));
        chk("hit_sound", int'(hit_sound), int'((m_now - 1 - m_hit_t) < SC));
        chk("miss_sound", int'(miss_sound), int'((m_now - 1 - m_miss_t) < SC));
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step(start_game, int'(box_address));
        @(negedge CLOCK_50);
        if (hit_sound) hi_count++;
        if (miss_sound) mi_count++;
        check_all();
    endtask

    task automatic wait_model_state(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin
            tick();
            n++;
        end
        chk_true("wait_state", m_state == s, m_state);
    endtask

    task automatic do_hit();
        wait_model_state(2, 100);
        box_address = 3'(m_target);
        repeat (3) tick();
        box_address = 3'd0;
    endtask

    task automatic apply_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    function automatic int sel_addr(input int sel);
        if (sel == 1) return m_target;
        if (sel == 2) return (m_target % NB) + 1;
        return 0;
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        start_game = 1'b0;
        box_address = 3'd0;
        model_reset();

        tbl[0] = '{1'b1, 0, 1,   1, 0};
        tbl[1] = '{1'b0, 0, 10,  2, 0};
        tbl[2] = '{1'b0, 1, 3,   1, 1};
        tbl[3] = '{1'b0, 0, 5,   2, 1};
        tbl[4] = '{1'b0, 2, 3,   2, 0};
        tbl[5] = '{1'b0, 0, 3,   2, 0};
        tbl[6] = '{1'b0, 2, 3,   2, 0};
        tbl[7] = '{1'b0, 0, 3,   2, 0};
        tbl[8] = '{1'b0, 0, 60,  2, 0};
        tbl[9] = '{1'b0, 0, 220, 3, 0};

        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (20) tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_lobby", int'(lobby_sound), 1);
        chk("rst_target", int'(target_box), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_seconds", int'(seconds_left), 3);

        for (int i = 0; i < 10; i++) begin
            start_game = tbl[i].start;
            box_address = 3'(sel_addr(tbl[i].sel));
            repeat (tbl[i].cycles) tick();
            chk("tbl_state", int'(state_o), tbl[i].exp_state);
            chk("tbl_score", int'(score), tbl[i].exp_score);
            tgt_snap[i] = int'(target_box);
            hi_snap[i] = hi_count;
            mi_snap[i] = mi_count;
        end
        start_game = 1'b0;
        chk_true("new_target_differs", tgt_snap[3] != tgt_snap[1], tgt_snap[3]);
        chk_true("new_target_range", tgt_snap[3] >= 1 && tgt_snap[3] <= NB, tgt_snap[3]);
        chk("hit_pulse_len", hi_snap[3] - hi_snap[1], 4);
        chk("target_kept_on_miss", tgt_snap[7], tgt_snap[3]);
        chk("miss_pulse_cycles", mi_snap[7] - mi_snap[3], 8);
        chk("over_game_over", int'(game_over), 1);
        chk("over_target", int'(target_box), 0);
        chk("over_seconds", int'(seconds_left), 0);

        // correct hit landing on the final-second edge
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        n = 0;
        while (m_elapsed < 297 && n < 400) begin
            tick();
            n++;
        end
        box_address = 3'(m_target);
        repeat (3) tick();
        chk("expiry_state", int'(state_o), 3);
        chk("expiry_score", int'(score), 1);
        box_address = 3'd0;
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        chk("restart_score", int'(score), 0);
        chk("restart_seconds", int'(seconds_left), 3);
        chk("restart_state", int'(state_o), 1);

        // asynchronous reset in WAIT_HIT with score 2
        do_hit();
        do_hit();
        wait_model_state(2, 20);
        chk("pre_reset_score", int'(score), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", int'(state_o), 0);
        chk("arst_target", int'(target_box), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_seconds", int'(seconds_left), 3);
        chk("arst_lobby", int'(lobby_sound), 1);
        chk("arst_hit", int'(hit_sound), 0);
        chk("arst_miss", int'(miss_sound), 0);
        chk("arst_over", int'(game_over), 0);
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            start_game = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: box_address = 3'd0;
                    1: box_address = 3'(m_target);
                    2: box_address = 3'($urandom_range(1, NB));
                    default: ;
                endcase
            end
            tick();
        end
        start_game = 1'b0;
        box_address = 3'd0;

`ifdef DIFFICULTY_RAMP_EN
        apply_reset();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        repeat (4) do_hit();
        tick();
        n = 0;
        while (state_o == 2'd2 && n < 200) begin
            n++;
            tick();
        end
        chk("ramp_window_short", n, 25);
        tick();
        n = 0;
        while (state_o == 2'd2 && n < 200) begin
            n++;
            tick();
        end
        chk("ramp_window_restored", n, 50);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
